// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------
// | instr_fetch : PC owner and instruction fetch over a ready-handshake memory
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
module instr_fetch #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_rd_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rdy,
   input  logic [15:0]     imem_data,
   output logic [15:0]     instr,
   output logic            instr_vld,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus1,
   input  logic [15:0]     alt_pc,
   input  logic            alt_pc_ctrl,
   input  logic            hlt,
   input  logic            stall,
   output logic            halted,
   output logic [15:0]     retired
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [15:0]     instr_q;
   logic [15:0]     retired_q;
   logic            rd_en_q;
   logic            vld_q;
   logic            halted_q;

   assign pc_plus1   = pc_q + PC_W'(1);
   assign pc         = pc_q;
   assign imem_addr  = pc_q;
   assign instr      = instr_q;
   assign retired    = retired_q;
   assign imem_rd_en = rd_en_q;
   assign instr_vld  = vld_q;
   assign halted     = halted_q;

   // Output flags are registered alongside the state so they track it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= 16'h0000;
         retired_q <= 16'h0000;
         rd_en_q   <= 1'b1;
         vld_q     <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imem_rdy) begin
                  instr_q <= imem_data;
                  state_q <= ST_EXEC;
                  rd_en_q <= 1'b0;
                  vld_q   <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (!stall) begin
                  retired_q <= retired_q + 16'd1;
                  vld_q     <= 1'b0;
                  if (hlt) begin
                     state_q  <= ST_HALT;
                     halted_q <= 1'b1;
                  end else begin
                     pc_q    <= alt_pc_ctrl ? alt_pc[PC_W-1:0] : pc_plus1;
                     state_q <= ST_FETCH;
                     rd_en_q <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
            end
            default: begin
               state_q  <= ST_FETCH;
               rd_en_q  <= 1'b1;
               vld_q    <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_instr_fetch : scoreboard bench for instr_fetch
// | Revision       : 1.0
// +-----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_rd_en;
   logic [15:0] imem_addr;
   logic        imem_rdy = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic [15:0] instr;
   logic        instr_vld;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic [15:0] alt_pc = 16'h0000;
   logic        alt_pc_ctrl = 1'b0;
   logic        hlt = 1'b0;
   logic        stall = 1'b0;
   logic        halted;
   logic [15:0] retired;

   instr_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_rd_en (imem_rd_en),
      .imem_addr  (imem_addr),
      .imem_rdy   (imem_rdy),
      .imem_data  (imem_data),
      .instr      (instr),
      .instr_vld  (instr_vld),
      .pc         (pc),
      .pc_plus1   (pc_plus1),
      .alt_pc     (alt_pc),
      .alt_pc_ctrl(alt_pc_ctrl),
      .hlt        (hlt),
      .stall      (stall),
      .halted     (halted),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] ret;
      logic [15:0] pcp1;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   waits  = 0;
   int   wcnt   = 0;
   bit   mem_auto = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive(input logic s, input logic h, input logic c, input logic [15:0] a);
      stall = s; hlt = h; alt_pc_ctrl = c; alt_pc = a;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rden"},    imem_rd_en, 1);
      chk({tag, "_addr"},    imem_addr,  16'h0000);
      chk({tag, "_pc"},      pc,         16'h0000);
      chk({tag, "_instr"},   instr,      16'h0000);
      chk({tag, "_retired"}, retired,    16'h0000);
      chk({tag, "_halted"},  halted,     0);
      chk({tag, "_vld"},     instr_vld,  0);
   endtask

   // Memory: contents are addr ^ 16'hBEEF, answering after `waits` stalled cycles.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mem_auto) begin
            if (imem_rd_en) begin
               if (wcnt >= waits) begin
                  imem_rdy  = 1'b1;
                  imem_data = imem_addr ^ 16'hBEEF;
               end else begin
                  imem_rdy = 1'b0;
                  wcnt++;
               end
            end else begin
               imem_rdy = 1'b0;
               wcnt     = 0;
            end
         end
      end
   end

   // Monitor: every cycle with instr_vld consumes one expected EXEC view.
   always @(negedge clk) begin
      if (instr_vld) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if ({pc, instr, retired, pc_plus1} !== e) begin
               errors++;
               $display("FAIL sb_item: got pc=%h instr=%h ret=%h pcp1=%h expected pc=%h instr=%h ret=%h pcp1=%h (cycle %0d)",
                        pc, instr, retired, pc_plus1, e.pc, e.instr, e.ret, e.pcp1, cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sb_q.push_back('{16'h0000, 16'hBEEF, 16'd0, 16'h0001});
      sb_q.push_back('{16'h0001, 16'hBEEE, 16'd1, 16'h0002});
      sb_q.push_back('{16'h0002, 16'hBEED, 16'd2, 16'h0003});
      sb_q.push_back('{16'h0003, 16'hBEEC, 16'd3, 16'h0004});
      sb_q.push_back('{16'h0010, 16'hBEFF, 16'd4, 16'h0011});
      sb_q.push_back('{16'h0042, 16'hBEAD, 16'd5, 16'h0043});
      for (int k = 0; k < 3; k++)
         sb_q.push_back('{16'h0043, 16'hBEAC, 16'd6, 16'h0044});
      sb_q.push_back('{16'h0000, 16'hBEEF, 16'd0, 16'h0001});
      sb_q.push_back('{16'hFFFF, 16'h4110, 16'd1, 16'h0000});
      sb_q.push_back('{16'h0000, 16'hBEEF, 16'd2, 16'h0001});
      sb_q.push_back('{16'h0000, 16'hBEEF, 16'd0, 16'h0001});

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 1;
      chk_reset("rst0");

      // Zero-wait sequential fetch: FETCH on odd cycles, EXEC on even.
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) tick();
         chk("seq_rden", imem_rd_en, (i % 2) == 1);
         chk("seq_vld",  instr_vld,  (i % 2) == 0);
         if (i % 2 == 1) chk("seq_addr", imem_addr, (i - 1) / 2);
         if (i == 6) waits = 3;
      end

      tick();
      chk("seq_retired", retired, 16'd3);
      chk("seq_pc", pc, 16'h0003);
      for (int i = 7; i <= 10; i++) begin
         if (i > 7) tick();
         chk("wait_rden",  imem_rd_en, 1);
         chk("wait_addr",  imem_addr,  16'h0003);
         chk("wait_vld",   instr_vld,  0);
         chk("wait_instr", instr,      16'hBEED);
         drive(1'b1, 1'b1, 1'b1, 16'h0FF0);
      end

      tick();
      chk("wait_done_instr", instr, 16'hBEEC);
      drive(1'b0, 1'b0, 1'b1, 16'h0010);
      waits = 0;
      tick();
      chk("redir1_addr", imem_addr, 16'h0010);
      drive(1'b1, 1'b1, 1'b1, 16'hDEAD);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0042);
      tick();
      chk("redir2_rden", imem_rd_en, 1);
      chk("redir2_addr", imem_addr, 16'h0042);
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      tick();
      chk("redir2_pcp1", pc_plus1, 16'h0043);
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      chk("seq43_addr", imem_addr, 16'h0043);
      drive(1'b0, 1'b1, 1'b0, 16'h0000);

      // Stall outranks halt and redirect; then halt outranks redirect.
      tick();
      chk("stall0_vld", instr_vld, 1);
      drive(1'b1, 1'b1, 1'b1, 16'h0042);
      tick();
      chk("stall1_vld", instr_vld, 1);
      drive(1'b1, 1'b0, 1'b0, 16'h0000);
      tick();
      chk("stall2_vld", instr_vld, 1);
      drive(1'b0, 1'b1, 1'b1, 16'h0042);
      for (int i = 20; i <= 22; i++) begin
         tick();
         chk("halt_halted",  halted,     1);
         chk("halt_pc",      pc,         16'h0043);
         chk("halt_retired", retired,    16'd7);
         chk("halt_rden",    imem_rd_en, 0);
         chk("halt_vld",     instr_vld,  0);
         chk("halt_instr",   instr,      16'hBEAC);
         drive(1'b0, 1'b0, 1'b1, 16'h1111);
      end
      rst = 1'b1;

      tick();
      chk_reset("rst_halt");
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
      tick();
      chk("wrap_addr_ffff", imem_addr, 16'hFFFF);
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      chk("wrap_pcp1", pc_plus1, 16'h0000);
      tick();
      chk("wrap_rden", imem_rd_en, 1);
      chk("wrap_addr", imem_addr, 16'h0000);
      tick();
      mem_auto  = 1'b0;
      imem_rdy  = 1'b0;
      tick();
      chk("mid_addr", imem_addr, 16'h0001);
      tick();
      chk("mid_rden",  imem_rd_en, 1);
      chk("mid_instr", instr, 16'hBEEF);
      tick();
      imem_rdy  = 1'b1;
      imem_data = 16'h1234;
      rst       = 1'b1;
      tick();
      chk_reset("rst_wait");
      rst      = 1'b0;
      imem_rdy = 1'b0;
      mem_auto = 1'b1;
      tick();
      drive(1'b0, 1'b1, 1'b0, 16'h0000);
      tick();
      chk("final_halted",  halted,  1);
      chk("final_retired", retired, 16'd1);
      chk("final_pc",      pc,      16'h0000);
      repeat (3) tick();
      chk("sb_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and program-counter stage of the single-cycle processor, directly upstream of the instruction decode stage. Owns the architectural PC, reads instructions from a variable-latency instruction memory over a ready handshake, and presents one instruction at a time to decode. It consumes decode's redirect (`alt_pc`, `alt_pc_ctrl`) and halt (`hlt`) outputs to choose the next PC or stop fetching.

## Interface
- `PC_W`, 16, PC and instruction-memory address width.
- `RESET_PC`, 16'h0000, PC value loaded by reset.
- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `imem_rd_en` out 1 — instruction read request.
- `imem_addr` out PC_W — read address; equals `pc` whenever `imem_rd_en`=1.
- `imem_rdy` in 1 — memory returns `imem_data` in this cycle; ignored while `imem_rd_en`=0.
- `imem_data` in 16 — instruction word, valid when `imem_rdy`=1.
- `instr` out 16 — registered instruction to decode.
- `instr_vld` out 1 — `instr` is live and decode outputs are to be acted on.
- `pc` out PC_W — address of `instr`; feeds decode `PC`.
- `pc_plus1` out PC_W — `pc`+1 modulo 2^PC_W; feeds the JAL link write.
- `alt_pc` in 16, `alt_pc_ctrl` in 1 — redirect target and enable from decode.
- `hlt` in 1 — halt from decode.
- `stall` in 1 — hold the current instruction in EXEC (no commit).
- `halted` out 1 — processor stopped.
- `retired` out 16 — committed-instruction count.

## Operation
- FSM states: FETCH, EXEC, HALT.
- FETCH: `imem_rd_en`=1, `imem_addr`=`pc`, `instr_vld`=0. Stay until `imem_rdy`=1 sampled; then `instr`<=`imem_data` and go to EXEC. Address held stable for the whole wait.
- EXEC: `imem_rd_en`=0, `instr_vld`=1. Decode is combinational on `instr`/`pc`.
  - `stall`=1: no state change, `instr`, `pc` held, `instr_vld` stays 1.
  - else `hlt`=1: go to HALT, `pc` unchanged, `retired`+=1.
  - else `alt_pc_ctrl`=1: `pc`<=`alt_pc`, `retired`+=1, go to FETCH.
  - else: `pc`<=`pc_plus1`, `retired`+=1, go to FETCH.
  - Priority: `stall` > `hlt` > `alt_pc_ctrl` > sequential.
- HALT: `halted`=1, `imem_rd_en`=0, `instr_vld`=0; `pc`, `instr` and `retired` frozen. Only `rst` exits.
- `pc_plus1` is combinational from `pc`; wraps 16'hFFFF -> 16'h0000, with no flag.
- `retired` wraps at 16'hFFFF -> 0.
- `alt_pc`, `alt_pc_ctrl`, `hlt` and `stall` are don't-care outside EXEC, including X values.

## Timing
- Reset, applied while `rst`=1 at a clock edge: state=FETCH, `pc`=RESET_PC, `instr`=16'h0000, `retired`=0, `halted`=0. The first request is issued in the cycle after the reset edge.
- Output values in the cycle after reset: `imem_rd_en`=1, `instr_vld`=0.
- `rst` beats everything, including mid-wait, in EXEC, and in HALT. A returning `imem_rdy` on the reset edge is discarded.
- Zero-wait memory (`imem_rdy`=1 in the first FETCH cycle): 2 cycles per instruction (FETCH, EXEC).
- N wait cycles add N cycles to the above.
- The redirect or halt decision uses decode inputs sampled on the EXEC-exit edge. The next FETCH presents the new `pc` on `imem_addr` in the following cycle.
- `instr_vld` is high for exactly one cycle per instruction, plus one cycle per stalled cycle.

## Test plan
- Reset and sequential fetch: RESET_PC=0, zero-wait memory holding non-branch words at 0..3.
  - `imem_addr` must be 0,–,1,–,2 on alternating cycles.
  - `instr_vld` must pulse on cycles 2,4,6.
  - `retired` must be 3 after the third EXEC.
- Wait states: `imem_rdy` delayed 3 cycles.
  - `imem_rd_en` and `imem_addr` must be held for 4 cycles.
  - `instr` must update only on the `imem_rdy` edge.
- Redirect: in EXEC with `pc`=16'h0010, drive `alt_pc_ctrl`=1, `alt_pc`=16'h0042.
  - Next FETCH must have `imem_addr`=16'h0042.
  - In the next EXEC, `pc_plus1` must be 16'h0043.
- Stall and halt: hold `stall`=1 for 2 EXEC cycles, then `hlt`=1 together with `alt_pc_ctrl`=1.
  - `instr_vld` must stay high for 3 cycles.
  - `halted`=1 must follow, with `pc` unchanged and `retired` incremented by exactly 1.
  - `imem_rd_en`=0 must hold thereafter.
- Wrap-around: `pc`=16'hFFFF with a sequential commit.
  - `pc_plus1` must be 16'h0000 and the next `imem_addr` must be 16'h0000.
- Reset mid-operation: assert `rst` during a FETCH wait with `imem_rdy` pulsing on the same edge, and separately while in HALT.
  - Both cases must return to FETCH at RESET_PC with `instr`=0, `retired`=0, `halted`=0.
